// File: rtl/prio_rr_sched.sv
// Priority scheduler with round-robin tie-break and a registered output slot.
// Define AGING_EN to boost the priority of requesters that keep waiting.
module prio_rr_sched #(
  parameter int N         = 8,
  parameter int PW        = 8,
  parameter int IW        = $clog2(N),
  parameter int AGE_TICKS = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*PW-1:0] req_prio,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [IW-1:0]   out_data,
  input  logic            out_ready
);

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_data;
  logic [IW-1:0]   w_data_nxt;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   w_rr_nxt;
  logic [N*PW-1:0] w_eff;
  logic            w_slot_free;
  logic            w_grant;
  logic            w_found;
  logic [PW-1:0]   w_best;
  int              w_idx;
  int              w_win_i;
  logic [IW-1:0]   w_win;

  if (N < 2 || N > 16 || AGE_TICKS < 1) begin : g_bad_cfg
    $error("prio_rr_sched: unsupported N or AGE_TICKS");
  end

`ifdef AGING_EN
  localparam int WCW = $clog2(AGE_TICKS) + 1;

  for (genvar gi = 0; gi < N; gi++) begin : g_age
    logic [WCW-1:0] r_wc;
    logic [PW-1:0]  r_boost;
    logic [PW:0]    w_sum;

    assign w_sum = {1'b0, req_prio[gi*PW +: PW]}
                 + {1'b0, r_boost};
    assign w_eff[gi*PW +: PW] =
      w_sum[PW] ? {PW{1'b1}} : w_sum[PW-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_wc    <= '0;
        r_boost <= '0;
      end else if (!req_valid[gi] || req_ready[gi]) begin
        r_wc    <= '0;
        r_boost <= '0;
      end else if (r_wc == WCW'(AGE_TICKS - 1)) begin
        r_wc <= '0;
        if (r_boost != {PW{1'b1}})
          r_boost <= r_boost + 1'b1;
      end else begin
        r_wc <= r_wc + 1'b1;
      end
    end
  end
`else
  assign w_eff = req_prio;
`endif

  // Scan from rr_ptr; strict '>' keeps the earliest tie in scan order.
  always_comb begin
    w_found = 1'b0;
    w_best  = '0;
    w_idx   = 0;
    w_win_i = int'(r_rr_ptr);
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % N;
      if (req_valid[w_idx] &&
          (!w_found || w_eff[w_idx*PW +: PW] > w_best)) begin
        w_found = 1'b1;
        w_best  = w_eff[w_idx*PW +: PW];
        w_win_i = w_idx;
      end
    end
  end

  assign w_win       = IW'(w_win_i);
  assign w_slot_free = (r_state == S_EMPTY) || out_ready;
  assign w_grant     = reset_n && w_slot_free && (|req_valid);
  assign w_rr_nxt    = (w_win == IW'(N - 1)) ? '0
                     : w_win + 1'b1;

  always_comb begin
    req_ready = '0;
    if (w_grant)
      req_ready[w_win] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    unique case (r_state)
      S_EMPTY: begin
        if (w_grant) begin
          w_state_nxt = S_FULL;
          w_data_nxt  = w_win;
        end
      end
      S_FULL: begin
        if (w_grant) begin
          w_data_nxt = w_win;
        end else if (out_ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_EMPTY;
      r_data   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      if (w_grant)
        r_rr_ptr <= w_rr_nxt;
    end
  end

  assign out_valid = (r_state == S_FULL);
  assign out_data  = r_data;

endmodule
